// File: rtl/hdc_msg_tokenizer.sv
// HDC spam classifier front end: lowers and maps message bytes to item-memory
// symbol indices, buffers them, then replays them to the bundling encoder.
module hdc_msg_tokenizer #(
    parameter int MAX_LENGTH = 200,
    parameter int NUM_CHAR   = 37,
    parameter int IDX_W      = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_char,
    input  logic             in_last,
    output logic             tok_valid,
    input  logic             tok_ready,
    output logic [IDX_W-1:0] tok_idx,
    output logic             tok_last,
    output logic [7:0]       msg_len,
    output logic             msg_ovf
);

    // state   | meaning
    // IDLE    | waiting for the first byte of a message
    // COLLECT | storing bytes until in_last
    // EMIT    | replaying buffered symbols to the encoder
    typedef enum logic [1:0] {IDLE, COLLECT, EMIT} state_t;

    localparam logic [7:0] MAX_L = 8'(MAX_LENGTH);

    if ((2 ** IDX_W) < NUM_CHAR) begin : g_idx_w_check
        $error("IDX_W too narrow for NUM_CHAR");
    end

    state_t           state;
    logic [IDX_W-1:0] mem [MAX_LENGTH];
    logic [7:0]       wr_cnt;
    logic [7:0]       rd_ptr;
    logic [7:0]       rd_nxt;
    logic [7:0]       lc;
    logic [IDX_W-1:0] char_idx;
    logic             accept;
    logic             room;
    logic [7:0]       next_len;

    always_comb begin
        lc       = (in_char >= 8'h41 && in_char <= 8'h5a) ? in_char + 8'd32 : in_char;
        char_idx = '0;
        // 'a' maps to 11 and '0' maps to 1
        if (lc >= 8'h61 && lc <= 8'h7a)
            char_idx = IDX_W'(lc - 8'h56);
        else if (lc >= 8'h30 && lc <= 8'h39)
            char_idx = IDX_W'(lc - 8'h2f);
    end

    assign accept   = in_valid & in_ready;
    assign room     = (wr_cnt < MAX_L);
    assign next_len = room ? wr_cnt + 8'd1 : wr_cnt;
    assign rd_nxt   = rd_ptr + 8'd1;

    // Buffer has no reset; contents are only read back after being written.
    always_ff @(posedge clk) begin
        if (accept && state == IDLE)
            mem[0] <= char_idx;
        else if (accept && state == COLLECT && room)
            mem[wr_cnt] <= char_idx;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            wr_cnt    <= '0;
            rd_ptr    <= '0;
            in_ready  <= 1'b1;
            tok_valid <= 1'b0;
            tok_idx   <= '0;
            tok_last  <= 1'b0;
            msg_len   <= '0;
            msg_ovf   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        wr_cnt  <= 8'd1;
                        msg_ovf <= 1'b0;
                        if (in_last) begin
                            state     <= EMIT;
                            in_ready  <= 1'b0;
                            tok_valid <= 1'b1;
                            tok_idx   <= char_idx;
                            tok_last  <= 1'b1;
                            msg_len   <= 8'd1;
                            rd_ptr    <= '0;
                        end else begin
                            state <= COLLECT;
                        end
                    end
                end
                COLLECT: begin
                    if (accept) begin
                        if (room)
                            wr_cnt <= next_len;
                        else
                            msg_ovf <= 1'b1;
                        if (in_last) begin
                            // First token comes from the buffer; mem[0] was filled in IDLE.
                            state     <= EMIT;
                            in_ready  <= 1'b0;
                            tok_valid <= 1'b1;
                            tok_idx   <= mem[0];
                            tok_last  <= (next_len == 8'd1);
                            msg_len   <= next_len;
                            rd_ptr    <= '0;
                        end
                    end
                end
                EMIT: begin
                    if (tok_ready) begin
                        if (tok_last) begin
                            state     <= IDLE;
                            in_ready  <= 1'b1;
                            tok_valid <= 1'b0;
                            tok_idx   <= '0;
                            tok_last  <= 1'b0;
                        end else begin
                            rd_ptr   <= rd_nxt;
                            tok_idx  <= mem[rd_nxt];
                            tok_last <= (rd_nxt == msg_len - 8'd1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hdc_msg_tokenizer.sv
// Self-checking bench for hdc_msg_tokenizer: directed cases plus randomized
// messages compared against a per-character reference model.
module tb_hdc_msg_tokenizer;
    localparam int MAX_LENGTH = 200;
    localparam int NUM_CHAR   = 37;
    localparam int IDX_W      = 6;

    logic             clk = 1'b0;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [7:0]       in_char;
    logic             in_last;
    logic             tok_valid;
    logic             tok_ready;
    logic [IDX_W-1:0] tok_idx;
    logic             tok_last;
    logic [7:0]       msg_len;
    logic             msg_ovf;

    hdc_msg_tokenizer #(.MAX_LENGTH(MAX_LENGTH), .NUM_CHAR(NUM_CHAR), .IDX_W(IDX_W)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_char(in_char), .in_last(in_last),
        .tok_valid(tok_valid), .tok_ready(tok_ready), .tok_idx(tok_idx), .tok_last(tok_last),
        .msg_len(msg_len), .msg_ovf(msg_ovf)
    );

    always #5 clk = ~clk;

    int         n_chk = 0;
    int         n_fail = 0;
    logic [7:0] msg_q[$];
    logic       rdy_pat[$];
    int         gap_pct = 0;
    int         ready_pct = 100;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int ref_idx(input logic [7:0] c);
        int v = int'(c);
        if (v >= 65 && v <= 90) v = v + 32;
        if (v >= 97 && v <= 122) return v - 97 + 11;
        if (v >= 48 && v <= 57) return v - 48 + 1;
        return 0;
    endfunction

    task automatic load_str(input string s);
        msg_q.delete();
        for (int i = 0; i < s.len(); i++) msg_q.push_back(s[i]);
    endtask

    task automatic load_fill(input logic [7:0] c, input int n);
        msg_q.delete();
        for (int i = 0; i < n; i++) msg_q.push_back(c);
    endtask

    // Called at a negedge; returns at the negedge after the last byte's edge.
    task automatic send_msg();
        for (int i = 0; i < msg_q.size(); i++) begin
            for (int g = 0; g < 6 && $urandom_range(0, 99) < gap_pct; g++) begin
                @(negedge clk);
                in_valid = 1'b0;
                in_char  = 8'($urandom);
            end
            @(negedge clk);
            check_val("in_ready_collect", in_ready, 1);
            in_valid = 1'b1;
            in_char  = msg_q[i];
            in_last  = (i == msg_q.size() - 1);
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        check_val("first_tok_latency", tok_valid, 1);
    endtask

    task automatic recv_msg();
        int n   = (msg_q.size() > MAX_LENGTH) ? MAX_LENGTH : msg_q.size();
        bit ovf = (msg_q.size() > MAX_LENGTH);
        int k   = 0;
        int cyc = 0;
        bit r;
        while (k < n && cyc < 5000) begin
            check_val("tok_valid", tok_valid, 1);
            check_val("tok_idx", tok_idx, ref_idx(msg_q[k]));
            check_val("tok_last", tok_last, (k == n - 1));
            check_val("msg_len", msg_len, n);
            check_val("msg_ovf", msg_ovf, ovf);
            check_val("in_ready_emit", in_ready, 0);
            if (rdy_pat.size() > 0) r = rdy_pat.pop_front();
            else r = ($urandom_range(0, 99) < ready_pct);
            tok_ready = r;
            in_valid  = 1'($urandom_range(0, 1));
            in_char   = 8'($urandom);
            in_last   = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (r) k++;
            cyc++;
        end
        if (k < n) check_val("emit_timeout", k, n);
        tok_ready = 1'b0;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        check_val("tok_valid_after", tok_valid, 0);
        check_val("in_ready_after", in_ready, 1);
    endtask

    task automatic run_msg();
        send_msg();
        recv_msg();
    endtask

    task automatic check_reset_state(input string tag);
        check_val({tag, "_in_ready"}, in_ready, 1);
        check_val({tag, "_tok_valid"}, tok_valid, 0);
        check_val({tag, "_tok_idx"}, tok_idx, 0);
        check_val({tag, "_tok_last"}, tok_last, 0);
        check_val({tag, "_msg_len"}, msg_len, 0);
        check_val({tag, "_msg_ovf"}, msg_ovf, 0);
    endtask

    logic [7:0] sweep [11] = '{8'h41, 8'h5a, 8'h61, 8'h7a, 8'h30, 8'h39,
                               8'h40, 8'h5b, 8'h60, 8'h7b, 8'h00};

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_char = '0; in_last = 1'b0; tok_ready = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_state("reset");
        reset = 1'b0;
        @(negedge clk);
        check_val("in_ready_idle", in_ready, 1);

        load_str("Hi5!");
        run_msg();

        for (int i = 0; i < 11; i++) begin
            msg_q.delete();
            msg_q.push_back(sweep[i]);
            run_msg();
        end

        load_str("ab");
        rdy_pat = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        run_msg();

        load_fill(8'h78, 205);
        run_msg();
        load_str("1");
        run_msg();

        load_fill(8'h39, 200);
        run_msg();

        load_str("hello");
        send_msg();
        for (int c = 0; c < 2; c++) begin
            check_val("hello_tok_idx", tok_idx, ref_idx(msg_q[c]));
            tok_ready = 1'b1;
            @(negedge clk);
        end
        reset = 1'b1;
        tok_ready = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        tok_ready = 1'b0;
        check_reset_state("midreset");
        load_str("ok");
        run_msg();

        gap_pct = 30;
        ready_pct = 60;
        for (int m = 0; m < 40; m++) begin
            int len = (m % 5 == 0) ? $urandom_range(195, 215) : $urandom_range(1, 24);
            msg_q.delete();
            for (int i = 0; i < len; i++) begin
                case ($urandom_range(0, 3))
                    0: msg_q.push_back(8'($urandom_range(65, 90)));
                    1: msg_q.push_back(8'($urandom_range(97, 122)));
                    2: msg_q.push_back(8'($urandom_range(48, 57)));
                    default: msg_q.push_back(8'($urandom));
                endcase
            end
            run_msg();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/hdc_msg_tokenizer.md
# hdc_msg_tokenizer

Upstream front end of the HDC spam classifier. Accepts a message as a byte stream with a valid/ready handshake and folds upper case to lower case. Maps each character to its item-memory symbol index and buffers up to MAX_LENGTH symbols. Once the last byte arrives, it replays the buffered indices one per handshake to the bundling encoder, together with the message length and an overflow flag.

## Interface
- MAX_LENGTH, 200, buffer depth in symbols; 1..255.
- NUM_CHAR, 37, symbol alphabet size; indices 0..NUM_CHAR-1.
- IDX_W, 6, symbol index width; must satisfy 2^IDX_W >= NUM_CHAR.
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high.
- in_valid  input  1  in_char/in_last valid.
- in_ready  output  1  tokenizer can accept a byte.
- in_char  input  8  ASCII byte.
- in_last  input  1  byte is the final byte of the message.
- tok_valid  output  1  tok_idx/tok_last valid.
- tok_ready  input  1  encoder accepts the token.
- tok_idx  output  IDX_W  symbol index.
- tok_last  output  1  final token of the message.
- msg_len  output  8  stored symbol count; stable while in EMIT.
- msg_ovf  output  1  message exceeded MAX_LENGTH; stable while in EMIT.

## Operation
- Mapping, combinational on in_char:
  - 'A'..'Z' are lowered by adding 32.
  - 'a'..'z' map to char-'a'+11, giving 11..36.
  - '0'..'9' map to char-'0'+1, giving 1..10.
  - Every other byte, including 0x00, maps to 0.
- States: IDLE, COLLECT, EMIT.
- IDLE:
  - in_ready=1.
  - An accepted byte is written at address 0, wr_cnt becomes 1, and msg_ovf is cleared.
  - If in_last=1 the next state is EMIT; otherwise it is COLLECT.
- COLLECT:
  - in_ready=1.
  - When wr_cnt<MAX_LENGTH, an accepted byte is written at wr_cnt and wr_cnt increments.
  - When wr_cnt=MAX_LENGTH, an accepted byte is dropped and msg_ovf is set (sticky).
  - An accepted byte with in_last=1 moves the state to EMIT; a dropped last byte also ends the message.
- Entering EMIT:
  - msg_len is loaded with wr_cnt.
  - rd_ptr is cleared to 0.
- EMIT:
  - in_ready=0.
  - tok_valid=1, tok_idx=buf[rd_ptr], tok_last=(rd_ptr==msg_len-1).
  - On a tok_valid&tok_ready handshake, rd_ptr increments.
  - If tok_last=1 at the handshake, the next state is IDLE.
- Outputs must not change while tok_valid=1 and tok_ready=0.
- Buffer: MAX_LENGTH x IDX_W register array or inferred RAM. A registered read is allowed only if tok_idx still meets the timing below.
- Minimum message length is 1, because in_last always accompanies a byte. A message can never be empty.

## Timing
- Reset values:
  - State=IDLE; wr_cnt=0, rd_ptr=0.
  - in_ready=1, tok_valid=0, tok_idx=0, tok_last=0, msg_len=0, msg_ovf=0.
  - Buffer contents are don't-care.
- Acceptance: a byte is accepted on a rising edge where in_valid&in_ready=1.
- Accepting the last byte at edge N gives tok_valid=1 with the first token valid from edge N+1.
- Throughput:
  - One byte per cycle while collecting.
  - One token per cycle while emitting with tok_ready held at 1.
- Turnaround: the tok_last handshake at edge M gives in_ready=1 from edge M+1. There is no bubble beyond the state change.
- A message of L bytes with no backpressure occupies L collect cycles followed by min(L,MAX_LENGTH) emit cycles.
- in_ready is a function of state only and never depends on in_valid. tok_valid does not depend on tok_ready.
- Reset mid-message or mid-emit:
  - Returns to IDLE with all outputs at their reset values on the next edge.
  - Any partial message is discarded.
  - reset takes priority over simultaneous handshakes.

## Test plan
- Basic mapping: stream "Hi5!" (0x48,0x69,0x35,0x21, last on 0x21) with tok_ready=1.
  - Tokens are 18,19,6,0.
  - tok_last is asserted only on 0.
  - msg_len=4, msg_ovf=0.
  - First tok_valid occurs 1 cycle after the last byte.
- Case/boundary sweep: single-byte messages 'A','Z','a','z','0','9','@','[','`','{',0x00.
  - Expected indices: 11, 36, 11, 36, 1, 10, 0, 0, 0, 0, 0.
  - Each token has tok_last=1 and msg_len=1.
- Backpressure: message "ab" with tok_ready toggling 0,1,0,0,1.
  - tok_idx 11 is held until its handshake, then 12 is held until its handshake.
  - in_ready stays 0 throughout EMIT and returns to 1 after the second handshake.
- Overflow: 205 bytes of 'x' with in_last on byte 205.
  - Exactly 200 tokens of 34 are emitted, tok_last on the 200th.
  - msg_len=200, msg_ovf=1.
  - The next message "1" yields msg_ovf=0 and token 2.
- Exact fill: 200 bytes of '9'.
  - 200 tokens of 10 are emitted.
  - msg_ovf=0.
- Reset mid-operation:
  - Assert reset on the 3rd emit cycle of "hello": all outputs return to reset values next cycle.
  - A following message "ok" emits 25,21 with msg_len=2.
